// File: rtl/sa_out_packer.sv
// sa_out_packer: ReLU, per-column 32-bit word packing, round-robin arbitration
// into a first-word-fall-through FIFO, and a flush sequencer that pads and
// drains partial words at the end of a convolution.
// Optional feature: define OUT_POOL_EN to enable 1x2 max-pooling ahead of
// the packers. Each column holds one value and emits max(r0, r1) per pair.
module sa_out_packer #(
    parameter int NUM_COL    = 16,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [DATA_WIDTH-1:0]  accu_data_i [NUM_COL],
    input  logic                          accu_valid_i [NUM_COL],
    input  logic                          flush_i,
    input  logic                          wr_ready_i,
    output logic                          wr_valid_o,
    output logic [4*DATA_WIDTH-1:0]       wr_data_o,
    output logic [$clog2(NUM_COL)-1:0]    wr_ch_o,
    output logic                          flush_done_o,
    output logic                          overflow_o,
    output logic                          busy_o
);
    localparam int CW = $clog2(NUM_COL);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = DATA_WIDTH;
    localparam int WW = 4*DATA_WIDTH;

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t              state_q;
    logic                flush_done_q;
    logic                overflow_q;
    logic [CW-1:0]       rr_ptr_q;
    logic                in_flush;

    logic [NUM_COL-1:0]  slot_full;
    logic [NUM_COL-1:0]  grant;
    logic [NUM_COL-1:0]  drop;
    logic [NUM_COL-1:0]  col_busy;
    logic [WW-1:0]       slot_word [NUM_COL];

    logic [CW+WW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr_q;
    logic [AW:0]         rd_ptr_q;
    logic                fifo_empty;
    logic                fifo_full;
    logic                pop;
    logic                can_push;
    logic                push;
    logic [CW-1:0]       gnt_idx;
    logic                gnt_found;

    assign in_flush = (state_q == S_FLUSH);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COL; gi++) begin : g_col
            logic [1:0]      cnt_q;
            logic [3*DW-1:0] shift_q;     // {b2, b1, b0}; new bytes enter at the top
            logic            slot_full_q;
            logic [WW-1:0]   slot_q;
            logic [DW-1:0]   relu;
            logic            byte_vld;
            logic [DW-1:0]   byte_val;
            logic            slot_free;
            logic [WW-1:0]   pad_word;

            assign relu      = accu_data_i[gi][DW-1] ? '0 : accu_data_i[gi];
            // A slot being granted this cycle empties on the same edge it may refill
            assign slot_free = !slot_full_q || grant[gi];

`ifdef OUT_POOL_EN
            logic            hold_vld_q;
            logic [DW-1:0]   hold_q;

            // Pooled byte source: pair max in normal mode, lone held value during flush
            always_comb begin
                byte_vld = 1'b0;
                byte_val = relu;
                if (in_flush) begin
                    byte_vld = hold_vld_q;
                    byte_val = hold_q;
                end else if (accu_valid_i[gi] && hold_vld_q) begin
                    byte_vld = 1'b1;
                    byte_val = (relu > hold_q) ? relu : hold_q;
                end
            end

            // Hold register: capture first of a pair, release on the second or on flush
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_vld_q <= 1'b0;
                    hold_q     <= '0;
                end else if (!in_flush && accu_valid_i[gi]) begin
                    if (hold_vld_q) begin
                        hold_vld_q <= 1'b0;
                    end else begin
                        hold_q     <= relu;
                        hold_vld_q <= 1'b1;
                    end
                end else if (in_flush && hold_vld_q && (cnt_q != 2'd3 || slot_free)) begin
                    hold_vld_q <= 1'b0;
                end
            end

            assign col_busy[gi] = (cnt_q != 2'd0) || slot_full_q || hold_vld_q;
`else
            // Every valid ReLU byte goes straight into the packer outside of flush
            always_comb begin
                byte_vld = accu_valid_i[gi] && !in_flush;
                byte_val = relu;
            end

            assign col_busy[gi] = (cnt_q != 2'd0) || slot_full_q;
`endif

            // Zero-padded partial word: valid bytes live in the top cnt_q lanes of shift_q
            always_comb begin
                case (cnt_q)
                    2'd1:    pad_word = {{(3*DW){1'b0}}, shift_q[3*DW-1 -: DW]};
                    2'd2:    pad_word = {{(2*DW){1'b0}}, shift_q[3*DW-1 -: 2*DW]};
                    default: pad_word = {{DW{1'b0}}, shift_q};
                endcase
            end

            // Packer and staging slot: shift bytes in, move full or padded words to the slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q       <= 2'd0;
                    shift_q     <= '0;
                    slot_full_q <= 1'b0;
                    slot_q      <= '0;
                end else begin
                    if (grant[gi]) begin
                        slot_full_q <= 1'b0;
                    end
                    if (byte_vld && cnt_q != 2'd3) begin
                        shift_q <= {byte_val, shift_q[3*DW-1:DW]};
                        cnt_q   <= cnt_q + 2'd1;
                    end else if (byte_vld && slot_free) begin
                        slot_q      <= {byte_val, shift_q};
                        slot_full_q <= 1'b1;
                        cnt_q       <= 2'd0;
                    end else if (in_flush && !byte_vld && cnt_q != 2'd0 && slot_free) begin
                        slot_q      <= pad_word;
                        slot_full_q <= 1'b1;
                        cnt_q       <= 2'd0;
                    end
                end
            end

            assign slot_full[gi] = slot_full_q;
            assign slot_word[gi] = slot_q;
            assign drop[gi]      = (accu_valid_i[gi] && in_flush) ||
                                   (!in_flush && byte_vld && cnt_q == 2'd3 && !slot_free);
        end
    endgenerate

    // Round-robin search from rr_ptr; scanning downward lets the nearest full slot win
    always_comb begin
        logic [CW-1:0] cand;
        cand      = '0;
        gnt_idx   = rr_ptr_q;
        gnt_found = 1'b0;
        for (int i = NUM_COL-1; i >= 0; i--) begin
            cand = CW'((int'(rr_ptr_q) + i) % NUM_COL);
            if (slot_full[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && wr_ready_i;
    assign can_push   = !fifo_full || pop;
    assign push       = gnt_found && can_push;

    // One-hot grant back to the winning column's staging slot
    always_comb begin
        grant          = '0;
        grant[gnt_idx] = push;
    end

    // FIFO storage: no reset needed, occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {gnt_idx, slot_word[gnt_idx]};
        end
    end

    // FIFO pointers and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                rr_ptr_q <= (gnt_idx == CW'(NUM_COL-1)) ? '0 : gnt_idx + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Flush sequencer with registered done pulse, plus sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            flush_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            if (|drop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (flush_i) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (!(|col_busy)) begin
                        state_q      <= S_IDLE;
                        flush_done_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr_valid_o   = !fifo_empty;
    assign {wr_ch_o, wr_data_o} = fifo_empty ? '0 : fifo_mem[rd_ptr_q[AW-1:0]];
    assign flush_done_o = flush_done_q;
    assign overflow_o   = overflow_q;
    assign busy_o       = (|col_busy) || !fifo_empty || in_flush;

endmodule

// File: tb/tb_sa_out_packer.sv
// Directed testbench for sa_out_packer: latency, ReLU, round-robin burst,
// overflow with back-pressure, flush padding/done pulse, and pooling.
module tb_sa_out_packer;
    localparam int NC = 16;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic signed [DW-1:0] accu_data [NC];
    logic                 accu_valid [NC];
    logic                 flush;
    logic                 wr_ready;
    logic                 wr_valid;
    logic [31:0]          wr_data;
    logic [3:0]           wr_ch;
    logic                 flush_done;
    logic                 overflow;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    sa_out_packer #(.NUM_COL(NC), .DATA_WIDTH(DW), .FIFO_DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .accu_data_i  (accu_data),
        .accu_valid_i (accu_valid),
        .flush_i      (flush),
        .wr_ready_i   (wr_ready),
        .wr_valid_o   (wr_valid),
        .wr_data_o    (wr_data),
        .wr_ch_o      (wr_ch),
        .flush_done_o (flush_done),
        .overflow_o   (overflow),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        for (int c = 0; c < NC; c++) begin
            accu_valid[c] = 1'b0;
            accu_data[c]  = '0;
        end
        flush = 1'b0;
    endtask

    task automatic do_reset();
        clr_in();
        wr_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %0b exp 0", wr_valid); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
        checks++; if (wr_ch !== 4'h0) begin errors++; $display("FAIL reset_wr_ch got %0d exp 0", wr_ch); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %0b exp 0", flush_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        $display("reset: outputs idle");
    endtask

    task automatic test_basic();
        for (int k = 0; k < 4; k++) begin
            accu_valid[0] = 1'b1;
            accu_data[0]  = 8'(k + 1);
            tick();
        end
        clr_in();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1 wr_valid got %0b exp 0", wr_valid); end
        tick();
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL basic_lat2 wr_valid got %0b exp 1", wr_valid); end
        checks++; if (wr_data !== 32'h04030201) begin errors++; $display("FAIL basic_data got %h exp 04030201", wr_data); end
        checks++; if (wr_ch !== 4'd0) begin errors++; $display("FAIL basic_ch got %0d exp 0", wr_ch); end
        $display("basic: ch %0d data %h", wr_ch, wr_data);
        tick();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL basic_pop wr_valid got %0b exp 0", wr_valid); end
    endtask

    task automatic test_relu();
        logic [7:0] vals [4];
        bit seen;
        vals = '{8'hFD, 8'h07, 8'h80, 8'h7F};
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            accu_valid[5] = 1'b1;
            accu_data[5]  = vals[k];
            tick();
        end
        clr_in();
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (wr_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL relu_timeout wr_valid got 0 exp 1"); end
        checks++; if (wr_data !== 32'h7F000700) begin errors++; $display("FAIL relu_data got %h exp 7f000700", wr_data); end
        checks++; if (wr_ch !== 4'd5) begin errors++; $display("FAIL relu_ch got %0d exp 5", wr_ch); end
        $display("relu: ch %0d data %h", wr_ch, wr_data);
        tick();
    endtask

    task automatic test_burst();
        logic [31:0] exp_w;
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) begin
                for (int c = 0; c < NC; c++) begin
                    accu_valid[c] = 1'b1;
                    accu_data[c]  = 8'(b*64 + c*4 + k);
                end
                tick();
            end
            clr_in();
            for (int w = 0; w < NC; w++) begin
                tick();
                for (int k = 0; k < 4; k++) exp_w[k*8 +: 8] = 8'(b*64 + w*4 + k);
                checks++;
                if (wr_valid !== 1'b1 || wr_ch !== 4'(w) || wr_data !== exp_w) begin
                    errors++;
                    $display("FAIL burst%0d_word%0d got v=%0b ch=%0d data=%h exp v=1 ch=%0d data=%h", b, w, wr_valid, wr_ch, wr_data, w, exp_w);
                end
                $display("burst%0d: ch %0d data %h", b, wr_ch, wr_data);
            end
            tick();
            checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL burst%0d_drained wr_valid got %0b exp 0", b, wr_valid); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w;
        do_reset();
        wr_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) begin
                for (int c = 0; c < NC; c++) begin
                    accu_valid[c] = 1'b1;
                    accu_data[c]  = 8'(b*64 + c*4 + k);
                end
                tick();
            end
            clr_in();
            repeat (20) tick();
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got %0b exp 0", overflow); end
        for (int k = 0; k < 4; k++) begin
            accu_valid[3] = 1'b1;
            accu_data[3]  = 8'(k + 1);
            tick();
        end
        clr_in();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", overflow); end
        wr_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < 4; k++) exp_w[k*8 +: 8] = 8'((i/16)*64 + (i%16)*4 + k);
            checks++;
            if (wr_valid !== 1'b1 || wr_ch !== 4'(i % 16) || wr_data !== exp_w) begin
                errors++;
                $display("FAIL ovf_word%0d got v=%0b ch=%0d data=%h exp v=1 ch=%0d data=%h", i, wr_valid, wr_ch, wr_data, i % 16, exp_w);
            end
            $display("overflow drain: ch %0d data %h", wr_ch, wr_data);
            tick();
        end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained wr_valid got %0b exp 0", wr_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
    endtask

    task automatic test_flush();
        int done_cnt;
        bit got;
        logic [31:0] got_data;
        logic [3:0] got_ch;
        do_reset();
        done_cnt = 0;
        got = 1'b0;
        got_data = '0;
        got_ch = '0;
        accu_valid[2] = 1'b1; accu_data[2] = 8'd9; tick();
        accu_data[2] = 8'd8; tick();
        clr_in();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_done_early got %0b exp 0", flush_done); end
        for (int i = 0; i < 20; i++) begin
            if (wr_valid === 1'b1) begin got = 1'b1; got_data = wr_data; got_ch = wr_ch; end
            if (flush_done === 1'b1) done_cnt++;
            tick();
        end
        checks++; if (!got || got_data !== 32'h00000809 || got_ch !== 4'd2) begin errors++; $display("FAIL flush_word got v=%0b ch=%0d data=%h exp v=1 ch=2 data=00000809", got, got_ch, got_data); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL flush_done_pulses got %0d exp 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b exp 0", busy); end
        $display("flush: ch %0d data %h done pulses %0d", got_ch, got_data, done_cnt);
        // Empty flush: done two cycles after acceptance; a valid during FLUSH is dropped
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL eflush_done_c1 got %0b exp 0", flush_done); end
        accu_valid[0] = 1'b1; accu_data[0] = 8'd5;
        tick();
        clr_in();
        checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL eflush_done_c2 got %0b exp 1", flush_done); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL eflush_ovf got %0b exp 1", overflow); end
        tick();
        checks++; if (flush_done !== 1'b0 || busy !== 1'b0 || wr_valid !== 1'b0) begin errors++; $display("FAIL eflush_after got done=%0b busy=%0b v=%0b exp 0 0 0", flush_done, busy, wr_valid); end
        $display("empty flush: done pulse seen, overflow %0b", overflow);
    endtask

    task automatic test_pool();
        logic [7:0] vals [5];
        logic [31:0] words [4];
        int n;
        bit ch_ok;
        vals = '{8'h05, 8'h09, 8'hFF, 8'h02, 8'h04};
        n = 0;
        ch_ok = 1'b1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            accu_valid[1] = 1'b1;
            accu_data[1]  = vals[k];
            tick();
        end
        clr_in();
        flush = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (wr_valid === 1'b1) begin
                if (n < 4) words[n] = wr_data;
                if (wr_ch !== 4'd1) ch_ok = 1'b0;
                $display("pool: ch %0d data %h", wr_ch, wr_data);
                n++;
            end
            tick();
            flush = 1'b0;
        end
        checks++; if (!ch_ok) begin errors++; $display("FAIL pool_ch got other exp 1"); end
`ifdef OUT_POOL_EN
        checks++; if (n != 1) begin errors++; $display("FAIL pool_count got %0d exp 1", n); end
        checks++; if (n < 1 || words[0] !== 32'h00040209) begin errors++; $display("FAIL pool_word got %h exp 00040209", words[0]); end
`else
        checks++; if (n != 2) begin errors++; $display("FAIL nopool_count got %0d exp 2", n); end
        checks++; if (n < 1 || words[0] !== 32'h02000905) begin errors++; $display("FAIL nopool_word0 got %h exp 02000905", words[0]); end
        checks++; if (n < 2 || words[1] !== 32'h00000004) begin errors++; $display("FAIL nopool_word1 got %h exp 00000004", words[1]); end
`endif
    endtask

    initial begin
        clr_in();
        wr_ready = 1'b1;
        test_reset();
        test_basic();
        test_relu();
        test_burst();
        test_overflow();
        test_flush();
        test_pool();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
